delta_splitter: RTL and testbench

//   Inverse of the delta counter: accepts one request {base, len} and emits it as a

---
 rtl/delta_splitter_pkg.sv | 25 ++
 rtl/delta_counter.sv | 50 +++++
 rtl/delta_splitter.sv | 159 +++++++++++++++
 tb/tb_delta_splitter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/delta_splitter_pkg.sv
// Shared definitions for the delta splitter.
//   WIDTH_DEF      default width of base/len
//   MAX_DELTA_DEF  default largest chunk (power of two)
//   DW             chunk delta width for the default MAX_DELTA
//   state_e        splitter FSM state encoding
//   chunk_t        one emitted chunk at default widths
package delta_splitter_pkg;

    localparam int unsigned WIDTH_DEF     = 16;
    localparam int unsigned MAX_DELTA_DEF = 8;
    localparam int unsigned DW            = $clog2(MAX_DELTA_DEF) + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] base;
        logic [DW-1:0]        delta;
        logic                 last;
        logic                 wrap;
    } chunk_t;

endpackage

// File: rtl/delta_counter.sv
// Loadable up/down counter that steps by a variable delta.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous zero, highest priority
//   load_i, d_i     load d_i (beats en_i)
//   en_i            step by delta_i, upward or downward according to down_i
//   q_o             current value
//   overflow_o      carry (up) or borrow (down) of q_o +/- delta_i, combinational,
//                   valid whether or not en_i is set
module delta_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] delta_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH:0]   step;

    always_comb begin
        if (down_i) begin
            step = {1'b0, cnt_q} - {1'b0, delta_i};
        end else begin
            step = {1'b0, cnt_q} + {1'b0, delta_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= d_i;
        end else if (en_i) begin
            cnt_q <= step[WIDTH-1:0];
        end
    end

    assign q_o        = cnt_q;
    assign overflow_o = step[WIDTH];

endmodule

// File: rtl/delta_splitter.sv
// Splits one request {base, len} into chunks {base, delta} of at most MAX_DELTA,
// optionally never crossing a MAX_DELTA-aligned boundary.
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous abort of the current request
//   req_valid_i/ready_o  request handshake; ready only in IDLE
//   req_base_i/len_i     request start and length (len 0 = consumed, no chunk)
//   chunk_valid_o/ready_i chunk handshake
//   chunk_base_o/delta_o chunk start and size (delta never 0 while valid)
//   chunk_last_o         final chunk of the request
//   chunk_wrap_o         chunk_base_o + chunk_delta_o carries out of WIDTH bits
//   busy_o               a request is in flight
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | ready for a request, no chunk presented
// ST_EMIT | presenting chunks until the last one is taken
module delta_splitter
    import delta_splitter_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned MAX_DELTA = MAX_DELTA_DEF,
    parameter bit          ALIGN     = 1'b1,
    localparam int unsigned CDW      = $clog2(MAX_DELTA) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_base_i,
    input  logic [WIDTH-1:0] req_len_i,
    output logic             chunk_valid_o,
    input  logic             chunk_ready_i,
    output logic [WIDTH-1:0] chunk_base_o,
    output logic [CDW-1:0]   chunk_delta_o,
    output logic             chunk_last_o,
    output logic             chunk_wrap_o,
    output logic             busy_o
);

    localparam int unsigned LOG2 = $clog2(MAX_DELTA);

    state_e           state_q;
    logic             valid_q;
    logic             ready_q;
    logic             busy_q;

    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] rem_q;
    logic             base_carry;
    logic             unused_rem_borrow;

    logic [CDW-1:0]   room;
    logic [CDW-1:0]   delta;
    logic             last;
    logic             accept;
    logic             handshake;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_delta;

    // room is 1..MAX_DELTA, so delta is never 0 while rem_q is nonzero
    always_comb begin
        room = CDW'(MAX_DELTA);
        if (ALIGN) begin
            room = CDW'(MAX_DELTA) - CDW'(base_q[LOG2-1:0]);
        end
        if (rem_q < WIDTH'(room)) begin
            delta = rem_q[CDW-1:0];
        end else begin
            delta = room;
        end
        last = (rem_q == WIDTH'(delta));
    end

    // clear_i wins over both the accept and the handshake of the same cycle
    assign accept    = ready_q & req_valid_i & ~clear_i;
    assign handshake = valid_q & chunk_ready_i;
    assign cnt_en    = handshake & ~clear_i;
    assign cnt_delta = WIDTH'(delta);

    delta_counter #(
        .WIDTH (WIDTH)
    ) u_rem_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .en_i       (cnt_en),
        .load_i     (accept),
        .down_i     (1'b1),
        .delta_i    (cnt_delta),
        .d_i        (req_len_i),
        .q_o        (rem_q),
        .overflow_o (unused_rem_borrow)
    );

    delta_counter #(
        .WIDTH (WIDTH)
    ) u_base_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .en_i       (cnt_en),
        .load_i     (accept),
        .down_i     (1'b0),
        .delta_i    (cnt_delta),
        .d_i        (req_base_i),
        .q_o        (base_q),
        .overflow_o (base_carry)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && (req_len_i != '0)) begin
                        state_q <= ST_EMIT;
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (handshake && last) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Data outputs read as zero whenever no chunk is presented
    assign req_ready_o   = ready_q;
    assign busy_o        = busy_q;
    assign chunk_valid_o = valid_q;
    assign chunk_base_o  = valid_q ? base_q : '0;
    assign chunk_delta_o = valid_q ? delta : '0;
    assign chunk_last_o  = valid_q & last;
    assign chunk_wrap_o  = valid_q & base_carry;

endmodule

// File: tb/tb_delta_splitter.sv
module tb_delta_splitter;
    import delta_splitter_pkg::*;

    logic            clk_i;
    logic            rst_ni;
    logic            clear_i;
    logic            req_valid_i;
    logic [15:0]     req_base_i;
    logic [15:0]     req_len_i;
    logic            chunk_ready_i;

    logic            a_req_ready, a_valid, a_last, a_wrap, a_busy;
    logic [15:0]     a_base;
    logic [DW-1:0]   a_delta;
    logic            n_req_ready, n_valid, n_last, n_wrap, n_busy;
    logic [15:0]     n_base;
    logic [DW-1:0]   n_delta;

    int nvec = 0;
    int nerr = 0;

    delta_splitter #(.WIDTH(16), .MAX_DELTA(8), .ALIGN(1'b1)) u_dut_a (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (a_req_ready),
        .req_base_i    (req_base_i),
        .req_len_i     (req_len_i),
        .chunk_valid_o (a_valid),
        .chunk_ready_i (chunk_ready_i),
        .chunk_base_o  (a_base),
        .chunk_delta_o (a_delta),
        .chunk_last_o  (a_last),
        .chunk_wrap_o  (a_wrap),
        .busy_o        (a_busy)
    );

    delta_splitter #(.WIDTH(16), .MAX_DELTA(8), .ALIGN(1'b0)) u_dut_n (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (n_req_ready),
        .req_base_i    (req_base_i),
        .req_len_i     (req_len_i),
        .chunk_valid_o (n_valid),
        .chunk_ready_i (chunk_ready_i),
        .chunk_base_o  (n_base),
        .chunk_delta_o (n_delta),
        .chunk_last_o  (n_last),
        .chunk_wrap_o  (n_wrap),
        .busy_o        (n_busy)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [15:0] b,
                         input logic [DW-1:0] d, input logic l, input logic w);
        chk({tag, ".a.valid"}, 32'(a_valid), 32'(v));
        chk({tag, ".a.base"},  32'(a_base),  32'(b));
        chk({tag, ".a.delta"}, 32'(a_delta), 32'(d));
        chk({tag, ".a.last"},  32'(a_last),  32'(l));
        chk({tag, ".a.wrap"},  32'(a_wrap),  32'(w));
    endtask

    task automatic chk_n(input string tag, input logic v, input logic [15:0] b,
                         input logic [DW-1:0] d, input logic l, input logic w);
        chk({tag, ".n.valid"}, 32'(n_valid), 32'(v));
        chk({tag, ".n.base"},  32'(n_base),  32'(b));
        chk({tag, ".n.delta"}, 32'(n_delta), 32'(d));
        chk({tag, ".n.last"},  32'(n_last),  32'(l));
        chk({tag, ".n.wrap"},  32'(n_wrap),  32'(w));
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, ".a.valid"}, 32'(a_valid),     32'd0);
        chk({tag, ".a.ready"}, 32'(a_req_ready), 32'd1);
        chk({tag, ".a.busy"},  32'(a_busy),      32'd0);
    endtask

    // base 0x0006, len 20, MAX 8
    logic [15:0]   al_base [4] = '{16'h0006, 16'h0008, 16'h0010, 16'h0018};
    logic [DW-1:0] al_delta[4] = '{4'd2, 4'd8, 4'd8, 4'd2};
    logic [15:0]   na_base [3] = '{16'h0006, 16'h000E, 16'h0016};
    logic [DW-1:0] na_delta[3] = '{4'd8, 4'd8, 4'd4};

    initial begin
        rst_ni        = 1'b0;
        clear_i       = 1'b0;
        req_valid_i   = 1'b0;
        req_base_i    = '0;
        req_len_i     = '0;
        chunk_ready_i = 1'b0;

        @(negedge clk_i);
        chk_idle_a("reset");
        chk_a("reset", 1'b0, 16'h0, 4'd0, 1'b0, 1'b0);
        chk("reset.n.ready", 32'(n_req_ready), 32'd1);
        rst_ni = 1'b1;

        // Same request into aligned and unaligned instances
        @(negedge clk_i);
        req_valid_i   = 1'b1;
        req_base_i    = 16'h0006;
        req_len_i     = 16'd20;
        chunk_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
            chk_a($sformatf("split%0d", i), 1'b1, al_base[i], al_delta[i], i == 3, 1'b0);
            if (i < 3) begin
                chk_n($sformatf("split%0d", i), 1'b1, na_base[i], na_delta[i], i == 2, 1'b0);
            end else begin
                chk("split3.n.valid", 32'(n_valid), 32'd0);
                chk("split3.n.ready", 32'(n_req_ready), 32'd1);
            end
        end
        @(negedge clk_i);
        chk_idle_a("split_done");

        // Wrap past 0xFFFF
        req_valid_i = 1'b1;
        req_base_i  = 16'hFFFC;
        req_len_i   = 16'd8;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk_a("wrap0", 1'b1, 16'hFFFC, 4'd4, 1'b0, 1'b1);
        chk_n("wrap0", 1'b1, 16'hFFFC, 4'd8, 1'b1, 1'b1);
        @(negedge clk_i);
        chk_a("wrap1", 1'b1, 16'h0000, 4'd4, 1'b1, 1'b0);
        chk("wrap1.n.valid", 32'(n_valid), 32'd0);
        @(negedge clk_i);
        chk_idle_a("wrap_done");

        // Empty request
        req_valid_i = 1'b1;
        req_base_i  = 16'h1234;
        req_len_i   = 16'd0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk_idle_a("len0");
        chk("len0.n.valid", 32'(n_valid), 32'd0);

        // Stall then clear
        req_valid_i = 1'b1;
        req_base_i  = 16'h0100;
        req_len_i   = 16'd40;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk_a("stall_c0", 1'b1, 16'h0100, 4'd8, 1'b0, 1'b0);
        @(negedge clk_i);
        chk_a("stall_c1", 1'b1, 16'h0108, 4'd8, 1'b0, 1'b0);
        chunk_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk_a($sformatf("stall%0d", i), 1'b1, 16'h0108, 4'd8, 1'b0, 1'b0);
            chk($sformatf("stall%0d.a.busy", i), 32'(a_busy), 32'd1);
        end
        clear_i       = 1'b1;
        chunk_ready_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk_idle_a("clear");
        chk_a("clear", 1'b0, 16'h0, 4'd0, 1'b0, 1'b0);
        chk("clear.n.valid", 32'(n_valid), 32'd0);

        // clear_i in IDLE blocks an accept in the same cycle
        clear_i     = 1'b1;
        req_valid_i = 1'b1;
        req_base_i  = 16'h0003;
        req_len_i   = 16'd3;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk_idle_a("clear_idle");
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk_a("post_clear", 1'b1, 16'h0003, 4'd3, 1'b1, 1'b0);
        chk_n("post_clear", 1'b1, 16'h0003, 4'd3, 1'b1, 1'b0);
        @(negedge clk_i);
        chk_idle_a("post_clear_done");

        // Async reset mid-request
        req_valid_i = 1'b1;
        req_base_i  = 16'h0000;
        req_len_i   = 16'd100;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk_a("rst_mid", 1'b1, 16'h0000, 4'd8, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        chk_idle_a("rst_async");
        chk("rst_async.n.valid", 32'(n_valid), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk_idle_a("rst_release");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
